// File: rtl/tank_input_pkg.sv
// Shared encodings for the tank player input controller: button bit indices,
// move direction codes and fire FSM states.
package tank_input_pkg;

    localparam int unsigned NumBtn   = 5;
    localparam int unsigned BtnUp    = 0;
    localparam int unsigned BtnDown  = 1;
    localparam int unsigned BtnLeft  = 2;
    localparam int unsigned BtnRight = 3;
    localparam int unsigned BtnFire  = 4;

    typedef enum logic [1:0] {
        DirUp    = 2'b00,
        DirDown  = 2'b01,
        DirLeft  = 2'b10,
        DirRight = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        StIdle,
        StFire,
        StCool,
        StWaitRel
    } fire_st_e;

    // Returns {valid, dir}. An axis with both opposing buttons pressed is ignored.
    function automatic logic [2:0] resolve_dir(input logic [NumBtn-1:0] lvl);
        logic up, down, left, right;
        up    = lvl[BtnUp] & ~lvl[BtnDown];
        down  = lvl[BtnDown] & ~lvl[BtnUp];
        left  = lvl[BtnLeft] & ~lvl[BtnRight];
        right = lvl[BtnRight] & ~lvl[BtnLeft];
        if (up)         return {1'b1, DirUp};
        else if (down)  return {1'b1, DirDown};
        else if (left)  return {1'b1, DirLeft};
        else if (right) return {1'b1, DirRight};
        else            return 3'b000;
    endfunction

endpackage

// File: rtl/btn_filter.sv
// Two-flop synchronizer followed by a consecutive-high-sample debounce filter
// for one button.
module btn_filter #(
    parameter int unsigned DebCount = 36863
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o
);

    localparam int unsigned CntW = $clog2(DebCount + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebCount);

    logic            sync1_q, sync2_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = 1'b0;
        if (!sync2_q) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
            level_d = (cnt_q == CntMax);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/player_input_ctrl.sv
// Debounced tank controls: direction moves with hold-repeat and a valid/ready
// handshake, plus a fire FSM with cooldown. TANK_AUTOFIRE_EN enables autofire.
module player_input_ctrl
    import tank_input_pkg::*;
#(
    parameter int unsigned DEB_COUNT   = 36863,
    parameter int unsigned REPEAT_DLY  = 12500000,
    parameter int unsigned REPEAT_RATE = 5000000,
    parameter int unsigned COOLDOWN    = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_raw_i,
    input  logic       game_active_i,
    output logic       move_valid_o,
    output logic [1:0] move_dir_o,
    input  logic       move_ready_i,
    output logic       fire_pulse_o,
    output logic [4:0] btn_level_o
);

    localparam int unsigned RepMax  = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned RepW    = $clog2(RepMax + 1);
    localparam int unsigned CoolW   = $clog2(COOLDOWN + 1);
    localparam logic [RepW-1:0]  RepDly  = RepW'(REPEAT_DLY);
    localparam logic [RepW-1:0]  RepRate = RepW'(REPEAT_RATE);
    localparam logic [CoolW-1:0] CoolMax = CoolW'(COOLDOWN);

    logic [NumBtn-1:0] btn_lvl;

    for (genvar i = 0; i < NumBtn; i++) begin : g_btn
        btn_filter #(
            .DebCount(DEB_COUNT)
        ) u_btn_filter (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_i  (btn_raw_i[i]),
            .level_o(btn_lvl[i])
        );
    end

    assign btn_level_o = btn_lvl;

    logic       dir_valid;
    logic [1:0] dir_cur;
    assign {dir_valid, dir_cur} = resolve_dir(btn_lvl);

    // Repeat generation
    logic            held_q, held_d;
    logic [1:0]      held_dir_q, held_dir_d;
    logic            rate_phase_q, rate_phase_d;
    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            req, req_change;

    always_comb begin
        held_d       = held_q;
        held_dir_d   = held_dir_q;
        rate_phase_d = rate_phase_q;
        rep_cnt_d    = rep_cnt_q;
        req          = 1'b0;
        req_change   = 1'b0;
        if (!game_active_i || !dir_valid) begin
            held_d       = 1'b0;
            rate_phase_d = 1'b0;
            rep_cnt_d    = '0;
        end else if (!held_q || (held_dir_q != dir_cur)) begin
            req          = 1'b1;
            req_change   = 1'b1;
            held_d       = 1'b1;
            held_dir_d   = dir_cur;
            rate_phase_d = 1'b0;
            rep_cnt_d    = RepW'(1);
        end else if (rep_cnt_q == (rate_phase_q ? RepRate : RepDly)) begin
            req          = 1'b1;
            rate_phase_d = 1'b1;
            rep_cnt_d    = RepW'(1);
        end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end
    end

    // Single-entry move slot; a direction change arriving while busy is parked.
    logic       mv_valid_q, mv_valid_d;
    logic [1:0] mv_dir_q, mv_dir_d;
    logic       park_q, park_d;
    logic [1:0] park_dir_q, park_dir_d;
    logic       xfer;

    assign xfer = mv_valid_q & move_ready_i;

    always_comb begin
        mv_valid_d = mv_valid_q;
        mv_dir_d   = mv_dir_q;
        park_d     = park_q;
        park_dir_d = park_dir_q;
        if (xfer) begin
            mv_valid_d = 1'b0;
        end
        if (!mv_valid_q || xfer) begin
            if (req) begin
                mv_valid_d = 1'b1;
                mv_dir_d   = dir_cur;
                park_d     = 1'b0;
            end else if (park_q) begin
                mv_valid_d = 1'b1;
                mv_dir_d   = park_dir_q;
                park_d     = 1'b0;
            end
        end else if (req_change) begin
            park_d     = 1'b1;
            park_dir_d = dir_cur;
        end
        if (!game_active_i) begin
            mv_valid_d = 1'b0;
            mv_dir_d   = 2'b00;
            park_d     = 1'b0;
        end
    end

    // Fire FSM
    fire_st_e         fire_st_q, fire_st_d;
    logic [CoolW-1:0] cool_cnt_q, cool_cnt_d;
    logic             fire_prev_q;
    logic             fire_lvl;

    assign fire_lvl = btn_lvl[BtnFire];

    always_comb begin
        fire_st_d  = fire_st_q;
        cool_cnt_d = cool_cnt_q;
        unique case (fire_st_q)
            StIdle: begin
                if (fire_lvl && !fire_prev_q) fire_st_d = StFire;
            end
            StFire: begin
                fire_st_d  = StCool;
                cool_cnt_d = CoolW'(1);
            end
            StCool: begin
                if (cool_cnt_q == CoolMax) begin
                    if (fire_lvl) begin
`ifdef TANK_AUTOFIRE_EN
                        fire_st_d = StFire;
`else
                        fire_st_d = StWaitRel;
`endif
                    end else begin
                        fire_st_d = StIdle;
                    end
                end else begin
                    cool_cnt_d = cool_cnt_q + 1'b1;
                end
            end
            StWaitRel: begin
                if (!fire_lvl) fire_st_d = StIdle;
            end
            default: fire_st_d = StIdle;
        endcase
        if (!game_active_i) begin
            fire_st_d  = StIdle;
            cool_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q       <= 1'b0;
            held_dir_q   <= 2'b00;
            rate_phase_q <= 1'b0;
            rep_cnt_q    <= '0;
            mv_valid_q   <= 1'b0;
            mv_dir_q     <= 2'b00;
            park_q       <= 1'b0;
            park_dir_q   <= 2'b00;
            fire_st_q    <= StIdle;
            cool_cnt_q   <= '0;
            fire_prev_q  <= 1'b0;
        end else begin
            held_q       <= held_d;
            held_dir_q   <= held_dir_d;
            rate_phase_q <= rate_phase_d;
            rep_cnt_q    <= rep_cnt_d;
            mv_valid_q   <= mv_valid_d;
            mv_dir_q     <= mv_dir_d;
            park_q       <= park_d;
            park_dir_q   <= park_dir_d;
            fire_st_q    <= fire_st_d;
            cool_cnt_q   <= cool_cnt_d;
            fire_prev_q  <= fire_lvl;
        end
    end

    assign move_valid_o = mv_valid_q;
    assign move_dir_o   = mv_dir_q;
    assign fire_pulse_o = (fire_st_q == StFire);

endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl: directed scenarios then random buttons/ready,
// checked every cycle against a run-length / schedule based reference model.
module tb_player_input_ctrl;

    localparam int Deb  = 4;
    localparam int Dly  = 10;
    localparam int Rate = 5;
    localparam int Cool = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn = '0;
    logic       active = 1'b1;
    logic       ready = 1'b1;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       fire_pulse;
    logic [4:0] btn_level;

    player_input_ctrl #(
        .DEB_COUNT  (Deb),
        .REPEAT_DLY (Dly),
        .REPEAT_RATE(Rate),
        .COOLDOWN   (Cool)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw_i    (btn),
        .game_active_i(active),
        .move_valid_o (move_valid),
        .move_dir_o   (move_dir),
        .move_ready_i (ready),
        .fire_pulse_o (fire_pulse),
        .btn_level_o  (btn_level)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model state
    int         run0[5], run1[5], run2[5];
    logic [4:0] m_lvl;
    int         m_cur, m_held;
    bit         m_slot, m_later;
    int         m_sdir, m_ldir;
    bit         m_fire_now, m_wait, m_prev;
    int         m_cool;

    int xq_cyc[$];
    int xq_dir[$];
    int pq[$];
    bit lvl0_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int resolve(input logic [4:0] l);
        if (l[0] != l[1]) return l[0] ? 0 : 1;
        if (l[2] != l[3]) return l[2] ? 2 : 3;
        return -1;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 5; b++) begin
            run0[b] = 0;
            run1[b] = 0;
            run2[b] = 0;
        end
        m_lvl = '0;
        m_cur = -1;
        m_held = 0;
        m_slot = 0;
        m_sdir = 0;
        m_later = 0;
        m_ldir = 0;
        m_fire_now = 0;
        m_wait = 0;
        m_prev = 0;
        m_cool = 0;
    endtask

    task automatic step();
        int  d;
        bit  req, chg, xfer;
        // DUT observations for the edge about to happen
        if (move_valid && ready) begin
            xq_cyc.push_back(cyc);
            xq_dir.push_back(int'(move_dir));
        end
        if (fire_pulse) pq.push_back(cyc);

        d = resolve(m_lvl);
        req = 0;
        chg = 0;
        if (!active) begin
            m_cur = -1;
            m_held = 0;
        end else if (d < 0) begin
            m_cur = -1;
        end else if (d != m_cur) begin
            req = 1;
            chg = 1;
            m_cur = d;
            m_held = 1;
        end else begin
            if (m_held == Dly || (m_held > Dly && (m_held - Dly) % Rate == 0)) req = 1;
            m_held++;
        end

        xfer = m_slot && ready;
        if (!active) begin
            m_slot = 0;
            m_sdir = 0;
            m_later = 0;
        end else if (!m_slot || xfer) begin
            if (req) begin
                m_slot = 1;
                m_sdir = d;
                m_later = 0;
            end else if (m_later) begin
                m_slot = 1;
                m_sdir = m_ldir;
                m_later = 0;
            end else begin
                m_slot = 0;
            end
        end else if (chg) begin
            m_later = 1;
            m_ldir = d;
        end

        if (!active) begin
            m_fire_now = 0;
            m_cool = 0;
            m_wait = 0;
        end else if (m_fire_now) begin
            m_fire_now = 0;
            m_cool = Cool;
        end else if (m_cool > 0) begin
            m_cool--;
            if (m_cool == 0 && m_lvl[4]) begin
`ifdef TANK_AUTOFIRE_EN
                m_fire_now = 1;
`else
                m_wait = 1;
`endif
            end
        end else if (m_wait) begin
            if (!m_lvl[4]) m_wait = 0;
        end else if (m_lvl[4] && !m_prev) begin
            m_fire_now = 1;
        end
        m_prev = m_lvl[4];

        // Level follows the raw run length seen two samples earlier.
        for (int b = 0; b < 5; b++) begin
            run2[b] = run1[b];
            run1[b] = run0[b];
            run0[b] = btn[b] ? ((run0[b] < 1000) ? run0[b] + 1 : 1000) : 0;
            m_lvl[b] = (run2[b] >= Deb + 1);
        end

        @(posedge clk);
        #1;
        cyc++;
        if (btn_level[0]) lvl0_seen = 1;
        chk("move_valid", 32'(move_valid), 32'(m_slot));
        if (m_slot) chk("move_dir", 32'(move_dir), 32'(m_sdir));
        chk("fire_pulse", 32'(fire_pulse), 32'(m_fire_now));
        chk("btn_level", 32'(btn_level), 32'(m_lvl));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(move_valid), 32'd0);
        chk({tag, "_dir"}, 32'(move_dir), 32'd0);
        chk({tag, "_fire"}, 32'(fire_pulse), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset");
        chk("reset_level", 32'(btn_level), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        xq_cyc.delete();
        xq_dir.delete();
        pq.delete();
    endtask

    initial begin
        int n;
        model_reset();
        lvl0_seen = 0;
        #1;
        check_zero_outputs("por");
        chk("por_level", 32'(btn_level), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(3);

        // Glitch on up: 3 high, 1 low, 3 high
        clear_logs();
        lvl0_seen = 0;
        btn = 5'b00001; run(3);
        btn = 5'b00000; run(1);
        btn = 5'b00001; run(3);
        btn = 5'b00000; run(10);
        chk("glitch_level", 32'(lvl0_seen), 32'd0);
        chk("glitch_moves", 32'(xq_cyc.size()), 32'd0);

        // Hold up for 40 cycles with ready high
        clear_logs();
        btn = 5'b00001; run(40);
        btn = 5'b00000; run(10);
        chk("hold_count_ge5", 32'(xq_cyc.size() >= 5), 32'd1);
        for (int i = 0; i < xq_cyc.size(); i++) begin
            chk("hold_dir", 32'(xq_dir[i]), 32'd0);
            if (i == 1) chk("hold_first_gap", 32'(xq_cyc[1] - xq_cyc[0]), 32'(Dly));
            if (i >= 2) chk("hold_rate_gap", 32'(xq_cyc[i] - xq_cyc[i-1]), 32'(Rate));
        end

        // Backpressure: right held with ready low
        clear_logs();
        ready = 1'b0;
        btn = 5'b01000; run(30);
        chk("bp_valid", 32'(move_valid), 32'd1);
        chk("bp_dir", 32'(move_dir), 32'd3);
        btn = 5'b00000; run(6);
        chk("bp_still_valid", 32'(move_valid), 32'd1);
        ready = 1'b1; run(15);
        chk("bp_one_xfer", 32'(xq_cyc.size()), 32'd1);
        if (xq_dir.size() > 0) chk("bp_xfer_dir", 32'(xq_dir[0]), 32'd3);

        // Conflict: left+right+down
        clear_logs();
        btn = 5'b01110; run(30);
        btn = 5'b00000; run(10);
        chk("conflict_some", 32'(xq_cyc.size() >= 1), 32'd1);
        for (int i = 0; i < xq_dir.size(); i++) chk("conflict_dir", 32'(xq_dir[i]), 32'd1);

        // Fire held 30 cycles
        clear_logs();
        btn = 5'b10000; run(30);
        btn = 5'b00000; run(15);
`ifdef TANK_AUTOFIRE_EN
        chk("autofire_count_ge3", 32'(pq.size() >= 3), 32'd1);
        for (int i = 1; i < pq.size(); i++) chk("autofire_gap", 32'(pq[i] - pq[i-1]), 32'd9);
`else
        chk("fire_once", 32'(pq.size()), 32'd1);
`endif

        // Reset mid-cooldown, then a fresh press still fires
        clear_logs();
        btn = 5'b10000; run(12);
        do_reset();
        btn = 5'b00000; run(5);
        chk("post_reset_no_fire", 32'(pq.size()), 32'd1);
        btn = 5'b10000; run(15);
        btn = 5'b00000; run(15);
        chk("post_reset_refire", 32'(pq.size()), 32'd2);

        // game_active low with a move pending
        ready = 1'b0;
        btn = 5'b00001; run(15);
        chk("ga_pending", 32'(move_valid), 32'd1);
        active = 1'b0; run(1);
        check_zero_outputs("ga_low");
        btn = 5'b00000; run(4);
        active = 1'b1; ready = 1'b1; run(5);

        // Random phase
        for (int k = 0; k < 250; k++) begin
            btn = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) btn = 5'b00000;
            n = $urandom_range(1, 25);
            for (int j = 0; j < n; j++) begin
                ready = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 99) == 0) active = ~active;
                if ($urandom_range(0, 9) == 0) active = 1'b1;
                step();
            end
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player_input_ctrl.md
PLAYER_INPUT_CTRL -- requirements
Module: player_input_ctrl

Interface
REQ-001 SHALL have parameter DEB_COUNT, default 36863 (16'h8fff): consecutive high samples before a filtered button asserts.
REQ-002 SHALL have parameter REPEAT_DLY, default 12500000: held-direction cycles from first move to first repeat.
REQ-003 SHALL have parameter REPEAT_RATE, default 5000000: cycles between subsequent repeats.
REQ-004 SHALL have parameter COOLDOWN, default 25000000: cycles after a fire before fire re-arms.
REQ-005 SHALL have port clk, input, 1: sole clock; all state on posedge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port btn_raw, input, 5: raw buttons {fire,right,left,down,up}, asynchronous, active-high.
REQ-008 SHALL have port game_active, input, 1: gates all command generation.
REQ-009 SHALL have port move_valid, output, 1: move command pending.
REQ-010 SHALL have port move_dir, output, 2: 00 up, 01 down, 10 left, 11 right; valid only with move_valid.
REQ-011 SHALL have port move_ready, input, 1: consumer accepts the move this cycle.
REQ-012 SHALL have port fire_pulse, output, 1: one-cycle shot request.
REQ-013 SHALL have port btn_level, output, 5: filtered button levels, for display/debug.

Function
REQ-014 SHALL pass each btn_raw bit through a 2-flop synchronizer; its latency counts toward filter delay.
REQ-015 SHALL filter each bit independently: a low sample clears its counter and drops the level in the next cycle; the level rises on the cycle after the counter reaches DEB_COUNT.
REQ-016 SHALL resolve direction: an opposing pair both high (up+down, left+right) masks that axis; remaining priority up>down>left>right.
REQ-017 SHALL issue a move when the resolved direction changes to a non-none value, then after REPEAT_DLY cycles held, then every REPEAT_RATE cycles.
REQ-018 SHALL hold move_valid and move_dir stable until the cycle move_ready is high; the transfer occurs on valid&ready.
REQ-019 SHALL coalesce rather than queue: a repeat tick while valid is pending is dropped; a direction change while pending replaces move_dir only after the pending transfer.
REQ-020 SHALL reset the repeat counter when the resolved direction changes or goes to none; move_valid already pending stays pending.
REQ-021 SHALL run the fire FSM IDLE->FIRE on a filtered fire rising edge; FIRE lasts one cycle and asserts fire_pulse.
REQ-022 SHALL go FIRE->COOL; COOL counts COOLDOWN cycles, then ->WAIT_REL if fire is held, else ->IDLE.
REQ-023 SHALL go WAIT_REL->IDLE when filtered fire is low.
REQ-024 SHALL, while game_active is low, force fire FSM to IDLE, clear repeat state, suppress new moves, and drop any pending move_valid.
REQ-025 SHALL use counters sized $clog2(param+1) bits; no counter wraps, each saturates or reloads at its terminal value.

Reset
REQ-026 SHALL, on rst_n low, clear immediately all synchronizers, filter counters, btn_level, move_valid, move_dir (00), fire_pulse, repeat counter, and set fire FSM to IDLE.
REQ-027 SHALL treat reset release mid-press as a fresh press requiring a full DEB_COUNT.

Configuration
REQ-028 SHALL support macro TANK_AUTOFIRE_EN: when defined, COOL->FIRE directly if fire is held at cooldown end (WAIT_REL unused); when undefined, behaviour is per REQ-022/023.

Structure
REQ-029 SHALL place direction encodings, fire FSM state encoding, and button bit indices in package tank_input_pkg.
REQ-030 SHALL implement the synchronizer and filter as sub-module btn_filter, instanced five times.

Verification (DEB_COUNT=4, REPEAT_DLY=10, REPEAT_RATE=5, COOLDOWN=8)
REQ-031 SHALL test glitch: up high 3 cycles, low 1, high 3 -> btn_level[0] never rises, no move.
REQ-032 SHALL test hold/repeat: up held 40 cycles, move_ready=1 -> moves dir 00 at first-accept T, T+10, T+15, T+20, ...
REQ-033 SHALL test backpressure: right held, move_ready=0 for 30 cycles -> move_valid=1, dir=11 stable, exactly one transfer when ready rises.
REQ-034 SHALL test conflict: left+right+down held -> only dir 01 issued.
REQ-035 SHALL test fire held 30 cycles -> one fire_pulse without macro; with TANK_AUTOFIRE_EN, pulses spaced 9 cycles apart.
REQ-036 SHALL test reset mid-cooldown and game_active low with move pending -> all outputs 0 next cycle, FSM IDLE.
